operand_fetch: RTL and testbench

- Requester-side reader of the integer register file. Sits between decode and execute.
- Drives the register file's two combinational read ports and bypasses the writeback value into the captured operands.
- Tracks in-flight destination registers with a per-register busy scoreboard and stalls on hazards.
- Presents operands to execute through a single registered valid/ready output stage.

---
 rtl/operand_fetch.sv | 140 ++++++++++++++
 tb/tb_operand_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, bypasses writeback, tracks busy destinations.
// Optional OPFETCH_STALL_CNT_EN adds a stall_cycles counter port.
module operand_fetch #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef OPFETCH_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_rs1,
  input  logic [AWIDTH-1:0] in_rs2,
  input  logic [AWIDTH-1:0] in_rd,
  input  logic              in_rd_wen,
  output logic [AWIDTH-1:0] rf_raddr1,
  output logic [AWIDTH-1:0] rf_raddr2,
  input  logic [DWIDTH-1:0] rf_rdata1,
  input  logic [DWIDTH-1:0] rf_rdata2,
  input  logic              wb_valid,
  input  logic [AWIDTH-1:0] wb_rd,
  input  logic [DWIDTH-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_rs1_data,
  output logic [DWIDTH-1:0] out_rs2_data,
  output logic [AWIDTH-1:0] out_rd,
  output logic              out_rd_wen
);

  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [DWIDTH-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [AWIDTH-1:0] out_rd_q, out_rd_d;
  logic              out_rd_wen_q, out_rd_wen_d;

  logic wbhit_rs1, wbhit_rs2, wbhit_rd;
  logic raw1, raw2, waw, hazard, accept;
  logic [DWIDTH-1:0] src1, src2;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign wbhit_rs1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
  assign wbhit_rs2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);
  assign wbhit_rd  = wb_valid && (wb_rd == in_rd)  && (in_rd  != '0);

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  assign raw1   = (in_rs1 != '0) && busy_q[in_rs1] && !wbhit_rs1;
  assign raw2   = (in_rs2 != '0) && busy_q[in_rs2] && !wbhit_rs2;
  assign waw    = in_rd_wen && (in_rd != '0) && busy_q[in_rd] && !wbhit_rd;
  assign hazard = raw1 || raw2 || waw;

  assign in_ready = rst_n && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign src1 = (in_rs1 == '0) ? '0 : (wbhit_rs1 ? wb_data : rf_rdata1);
  assign src2 = (in_rs2 == '0) ? '0 : (wbhit_rs2 ? wb_data : rf_rdata2);

  always_comb begin
    out_valid_d    = out_valid_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_rd_d       = out_rd_q;
    out_rd_wen_d   = out_rd_wen_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_rs1_data_d = src1;
      out_rs2_data_d = src2;
      out_rd_d       = in_rd;
      out_rd_wen_d   = in_rd_wen;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Set beats clear on the same index; register 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (accept && in_rd_wen && (in_rd == AWIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_valid && (wb_rd == AWIDTH'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q         <= '0;
      out_valid_q    <= 1'b0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_rd_q       <= '0;
      out_rd_wen_q   <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_rd_q       <= out_rd_d;
      out_rd_wen_q   <= out_rd_wen_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_rd       = out_rd_q;
  assign out_rd_wen   = out_rd_wen_q;

`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then randomized traffic against a behavioural model.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  operand_fetch #(.AWIDTH(5), .DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef OPFETCH_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_busy [32];
  bit          m_ov;
  logic [31:0] m_d1, m_d2;
  logic [4:0]  m_rd;
  bit          m_wen;
  int unsigned m_stall;
  logic        last_ready;

  function automatic bit wbhit(input bit wv, input logic [4:0] wr, input logic [4:0] r);
    return wv && (wr == r) && (r != 0);
  endfunction

  function automatic logic [31:0] srcval(input logic [4:0] r, input bit hit,
                                         input logic [31:0] wd, input logic [31:0] rfv);
    if (r == 0) return 32'h0;
    if (hit) return wd;
    return rfv;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input bit rn, input bit iv, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input bit w, input bit wv, input logic [4:0] wr,
                       input logic [31:0] wd, input bit ordy);
    bit hz, rdy, acc;
    bit n_busy [32];
    bit n_ov;
    logic [31:0] n_d1, n_d2;
    logic [4:0] n_rd;
    bit n_wen;
    int unsigned n_stall;
    rst_n = rn; in_valid = iv; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_wen = w;
    wb_valid = wv; wb_rd = wr; wb_data = wd; out_ready = ordy;
    @(negedge clk);
    hz = (s1 != 0 && m_busy[s1] && !wbhit(wv, wr, s1)) ||
         (s2 != 0 && m_busy[s2] && !wbhit(wv, wr, s2)) ||
         (w && d != 0 && m_busy[d] && !wbhit(wv, wr, d));
    rdy = rn && !hz && (!m_ov || ordy);
    acc = iv && rdy;
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("rf_raddr1", 64'(rf_raddr1), 64'(s1));
    check("rf_raddr2", 64'(rf_raddr2), 64'(s2));
    last_ready = in_ready;
    n_busy = m_busy; n_ov = m_ov; n_d1 = m_d1; n_d2 = m_d2; n_rd = m_rd; n_wen = m_wen;
    n_stall = m_stall + ((iv && !rdy) ? 1 : 0);
    if (!rn) begin
      foreach (n_busy[i]) n_busy[i] = 0;
      n_ov = 0; n_d1 = 0; n_d2 = 0; n_rd = 0; n_wen = 0; n_stall = 0;
    end else begin
      if (acc) begin
        n_ov = 1;
        n_d1 = srcval(s1, wbhit(wv, wr, s1), wd, rf[s1]);
        n_d2 = srcval(s2, wbhit(wv, wr, s2), wd, rf[s2]);
        n_rd = d; n_wen = w;
      end else if (ordy) begin
        n_ov = 0;
      end
      if (wv && wr != 0) n_busy[wr] = 0;
      if (acc && w && d != 0) n_busy[d] = 1;
    end
    @(posedge clk);
    #1;
    m_busy = n_busy; m_ov = n_ov; m_d1 = n_d1; m_d2 = n_d2; m_rd = n_rd; m_wen = n_wen;
    m_stall = n_stall;
    if (wv) rf[wr] = wd;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_rs1_data", 64'(out_rs1_data), 64'(m_d1));
    check("out_rs2_data", 64'(out_rs2_data), 64'(m_d2));
    check("out_rd", 64'(out_rd), 64'(m_rd));
    check("out_rd_wen", 64'(out_rd_wen), 64'(m_wen));
`ifdef OPFETCH_STALL_CNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    $display("cyc rst_n=%0d iv=%0d rs1=%0d rs2=%0d rd=%0d wen=%0d wb=%0d/%0d rdy=%0d ov=%0d", rn, iv,
             s1, s2, d, w, wv, wr, last_ready, out_valid);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hBAD0BAD0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_ov = 0; m_d1 = 0; m_d2 = 0; m_rd = 0; m_wen = 0; m_stall = 0;
    rst_n = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
    @(posedge clk); #1;

    // Reset with in_valid held high
    cycle(0, 1, 3, 4, 5, 1, 0, 0, 0, 1);
    check("reset_in_ready", 64'(last_ready), 64'(0));
    cycle(0, 1, 3, 4, 5, 1, 0, 0, 0, 1);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_rs1", 64'(out_rs1_data), 64'(0));

    // Basic issue
    rf[3] = 32'h11; rf[4] = 32'h22;
    cycle(1, 1, 3, 4, 5, 1, 0, 0, 0, 1);
    check("basic_rs1", 64'(out_rs1_data), 64'h11);
    check("basic_rs2", 64'(out_rs2_data), 64'h22);
    check("basic_rd", 64'(out_rd), 64'd5);

    // RAW stall, then resolved by same-cycle writeback bypass
    cycle(1, 1, 5, 0, 6, 0, 0, 0, 0, 1);
    check("raw_stall", 64'(last_ready), 64'(0));
    cycle(1, 1, 5, 0, 6, 0, 1, 5, 32'hDEAD, 1);
    check("bypass_ready", 64'(last_ready), 64'(1));
    check("bypass_data", 64'(out_rs1_data), 64'hDEAD);
    cycle(1, 1, 5, 0, 0, 0, 0, 0, 0, 1);
    check("busy5_cleared", 64'(last_ready), 64'(1));

    // Index 0 sources and writeback to 0
    cycle(1, 1, 0, 0, 0, 1, 1, 0, 32'hFFFF, 1);
    check("zero_rs1", 64'(out_rs1_data), 64'(0));
    check("zero_rs2", 64'(out_rs2_data), 64'(0));
    cycle(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    check("rd0_not_busy", 64'(last_ready), 64'(1));

    // Output stall for 3 cycles then back-to-back transfer
    cycle(1, 1, 3, 4, 9, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 1, 2, 10, 0, 0, 0, 0, 0);
      check("stall_hold_rd", 64'(out_rd), 64'd9);
    end
    cycle(1, 1, 1, 2, 10, 0, 0, 0, 0, 1);
    check("b2b_ready", 64'(last_ready), 64'(1));
    check("b2b_rd", 64'(out_rd), 64'd10);

    // Same-cycle writeback and re-set of rd=7
    cycle(1, 1, 0, 0, 7, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 7, 1, 1, 7, 32'h77, 1);
    check("waw_wb_accept", 64'(last_ready), 64'(1));
    cycle(1, 1, 7, 0, 0, 0, 0, 0, 0, 1);
    check("busy7_kept", 64'(last_ready), 64'(0));
    cycle(1, 1, 7, 0, 0, 0, 1, 7, 32'h78, 1);

    // Four stalled in_valid cycles after a fresh reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 8, 1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 8, 0, 0, 0, 0, 0, 0, 1);
`ifdef OPFETCH_STALL_CNT_EN
    check("stall_cnt_4", 64'(stall_cycles), 64'd4);
`endif
    cycle(1, 1, 8, 0, 0, 0, 1, 8, 32'h88, 1);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      bit rn, iv, w, wv, ordy;
      logic [4:0] s1, s2, d, wr;
      rn   = ($urandom_range(0, 99) != 0);
      iv   = ($urandom_range(0, 3) != 0);
      s1   = 5'($urandom_range(0, 7));
      s2   = 5'($urandom_range(0, 7));
      d    = 5'($urandom_range(0, 7));
      w    = ($urandom_range(0, 2) != 0);
      wv   = ($urandom_range(0, 9) < 4);
      wr   = 5'($urandom_range(0, 7));
      ordy = ($urandom_range(0, 9) < 7);
      cycle(rn, iv, s1, s2, d, w, wv, wr, $urandom, ordy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
